// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the MiniRISC data bus arbiter: FSM state
// encodings, owner index width and the default hold limit.
package data_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  localparam int IDX_W            = 3;
  localparam int DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/data_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin selector: first set request bit searching
// upward with wrap from last+1, so the most recent winner is served last.
import data_bus_arbiter_pkg::*;

module rr_priority_pick #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   index,
  output logic [NUM_REQ-1:0] onehot
);

  int cand;

  // NOTE: every output and temporary gets a default before the loop so no
  // path through this block leaves a value unassigned, which would infer a latch.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        index        = IDX_W'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter for the shared data memory bus with a one-cycle
// turnaround between tenures and optional preemption after MAX_HOLD cycles.
import data_bus_arbiter_pkg::*;

module data_bus_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     grant,
  input  logic [NUM_REQ*8-1:0]   m_addr,
  input  logic [NUM_REQ*8-1:0]   m_wdata,
  input  logic [NUM_REQ-1:0]     m_wr,
  input  logic [NUM_REQ-1:0]     m_rd,
  output logic [7:0]             bus_addr,
  output logic [7:0]             bus_wdata,
  output logic                   bus_wr,
  output logic                   bus_rd,
  output logic                   bus_busy,
  output logic [IDX_W-1:0]       owner,
  output logic                   hold_timeout
);

  // A zero limit still gets a one-bit counter; it simply never advances.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  arb_state_e           state;
  logic [IDX_W-1:0]     last;
  logic [HW-1:0]        hold_cnt;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_index;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 owner_req;
  logic                 others_req;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .index  (pick_index),
    .onehot (pick_onehot)
  );

  // grant is one-hot at owner while in GRANT, so it doubles as the owner mask.
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      grant        <= '0;
      bus_busy     <= 1'b0;
      owner        <= '0;
      last         <= IDX_W'(NUM_REQ - 1);
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      hold_timeout <= 1'b0;
      unique case (state)
        ARB_IDLE, ARB_GAP: begin
          if (pick_valid) begin
            state    <= ARB_GRANT;
            grant    <= pick_onehot;
            bus_busy <= 1'b1;
            owner    <= pick_index;
            last     <= pick_index;
            hold_cnt <= '0;
          end else begin
            state    <= ARB_IDLE;
            grant    <= '0;
            bus_busy <= 1'b0;
          end
        end
        ARB_GRANT: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          if (!owner_req) begin
            state    <= ARB_GAP;
            grant    <= '0;
            bus_busy <= 1'b0;
          end else if (MAX_HOLD != 0 && hold_cnt == HOLD_MAX && others_req) begin
            state        <= ARB_GAP;
            grant        <= '0;
            bus_busy     <= 1'b0;
            hold_timeout <= 1'b1;
          end
        end
        default: begin
          state    <= ARB_IDLE;
          grant    <= '0;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

  // Only the granted master reaches the bus; idle and turnaround drive zeros.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        bus_addr  = m_addr[8*i +: 8];
        bus_wdata = m_wdata[8*i +: 8];
        bus_wr    = m_wr[i];
        bus_rd    = m_rd[i];
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: each driven cycle pushes the
// expected registered outputs, a negedge monitor pops and compares them.
module tb_data_bus_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int MAX_HOLD = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ*8-1:0] m_addr;
  logic [NUM_REQ*8-1:0] m_wdata;
  logic [NUM_REQ-1:0]   m_wr;
  logic [NUM_REQ-1:0]   m_rd;
  logic [7:0]           bus_addr;
  logic [7:0]           bus_wdata;
  logic                 bus_wr;
  logic                 bus_rd;
  logic                 bus_busy;
  logic [2:0]           owner;
  logic                 hold_timeout;

  data_bus_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_wr         (m_wr),
    .m_rd         (m_rd),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wr       (bus_wr),
    .bus_rd       (bus_rd),
    .bus_busy     (bus_busy),
    .owner        (owner),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    logic [2:0]  grant;
    logic [2:0]  owner;
    logic        tmo;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        wr;
    logic        rd;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Fixed master traffic; master 2 always presents 8'hA5 with a write strobe.
  localparam logic [23:0] ADDR  = {8'hA5, 8'h22, 8'h11};
  localparam logic [23:0] WDATA = {8'hC3, 8'hB2, 8'hA1};
  localparam logic [2:0]  WR    = 3'b110;
  localparam logic [2:0]  RD    = 3'b001;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".grant"},   32'(grant),        32'(e.grant));
      check({e.tag, ".busy"},    32'(bus_busy),     32'(e.grant != 3'b000));
      check({e.tag, ".owner"},   32'(owner),        32'(e.owner));
      check({e.tag, ".timeout"}, 32'(hold_timeout), 32'(e.tmo));
      check({e.tag, ".addr"},    32'(bus_addr),     32'(e.addr));
      check({e.tag, ".wdata"},   32'(bus_wdata),    32'(e.wdata));
      check({e.tag, ".wr"},      32'(bus_wr),       32'(e.wr));
      check({e.tag, ".rd"},      32'(bus_rd),       32'(e.rd));
    end
  end

  // Drive req for one cycle and queue what the registered outputs must be
  // after the next rising edge.
  task automatic cycle(input string tag, input logic [2:0] r,
                       input logic [2:0] eg, input logic [2:0] eo, input logic et);
    exp_t e;
    logic [23:0] a;
    logic [23:0] d;
    logic [2:0]  w;
    logic [2:0]  rd;
    a = ADDR; d = WDATA; w = WR; rd = RD;
    req     = r;
    e.cyc   = cyc + 1;
    e.tag   = tag;
    e.grant = eg;
    e.owner = eo;
    e.tmo   = et;
    e.addr  = 8'h00;
    e.wdata = 8'h00;
    e.wr    = 1'b0;
    e.rd    = 1'b0;
    if (eg != 3'b000) begin
      e.addr  = a[8*eo +: 8];
      e.wdata = d[8*eo +: 8];
      e.wr    = w[eo];
      e.rd    = rd[eo];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle("reset", 3'b000, 3'b000, 3'd0, 1'b0);
    rst = 1'b0;
  endtask

  // One tenure of master k under full contention: three grant cycles, then
  // k drops its request for the cycle that produces the turnaround.
  task automatic tenure(input string tag, input int k);
    logic [2:0] oh;
    oh = 3'(1 << k);
    for (int i = 0; i < 3; i++) cycle(tag, 3'b111, oh, 3'(k), 1'b0);
    cycle({tag, ".gap"}, 3'b111 & ~oh, 3'b000, 3'(k), 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    m_addr  = ADDR;
    m_wdata = WDATA;
    m_wr    = WR;
    m_rd    = RD;
    @(posedge clk);
    #1;

    // Reset then single request from master 1.
    do_reset();
    cycle("single", 3'b010, 3'b010, 3'd1, 1'b0);
    cycle("single.gap", 3'b000, 3'b000, 3'd1, 1'b0);
    cycle("single.idle", 3'b000, 3'b000, 3'd1, 1'b0);

    // Simultaneous start: rotation 0,1,2,0 with one dead cycle between.
    do_reset();
    tenure("rr0", 0);
    tenure("rr1", 1);
    tenure("rr2", 2);
    cycle("rr0b", 3'b111, 3'b001, 3'd0, 1'b0);
    cycle("rr.end", 3'b000, 3'b000, 3'd0, 1'b0);
    cycle("rr.idle", 3'b000, 3'b000, 3'd0, 1'b0);

    // Preemption: master 0 holds, master 2 waits; 5 grant cycles max.
    do_reset();
    cycle("pre.g0", 3'b001, 3'b001, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("pre.hold", 3'b101, 3'b001, 3'd0, 1'b0);
    cycle("pre.tmo", 3'b101, 3'b000, 3'd0, 1'b1);
    cycle("pre.g2", 3'b101, 3'b100, 3'd2, 1'b0);
    cycle("pre.g2b", 3'b101, 3'b100, 3'd2, 1'b0);
    cycle("pre.gap2", 3'b001, 3'b000, 3'd2, 1'b0);
    cycle("pre.regrant0", 3'b001, 3'b001, 3'd0, 1'b0);
    cycle("pre.end", 3'b000, 3'b000, 3'd0, 1'b0);
    cycle("pre.idle", 3'b000, 3'b000, 3'd0, 1'b0);

    // Uncontended hold well past MAX_HOLD: no preemption, no timeout.
    for (int i = 0; i < 40; i++) cycle("solo", 3'b010, 3'b010, 3'd1, 1'b0);
    cycle("solo.gap", 3'b000, 3'b000, 3'd1, 1'b0);
    cycle("solo.idle", 3'b000, 3'b000, 3'd1, 1'b0);

    // Isolation: master 2 strobes a write at 8'hA5 while master 0 owns the bus.
    cycle("iso.g0", 3'b001, 3'b001, 3'd0, 1'b0);
    cycle("iso.g0b", 3'b001, 3'b001, 3'd0, 1'b0);
    cycle("iso.gap", 3'b000, 3'b000, 3'd0, 1'b0);
    cycle("iso.idle", 3'b000, 3'b000, 3'd0, 1'b0);

    // Reset mid-tenure drops the grant with no turnaround, then master 0 wins.
    do_reset();
    cycle("rmt.g1", 3'b010, 3'b010, 3'd1, 1'b0);
    cycle("rmt.g1b", 3'b010, 3'b010, 3'd1, 1'b0);
    rst = 1'b1;
    cycle("rmt.rst", 3'b010, 3'b000, 3'd0, 1'b0);
    rst = 1'b0;
    cycle("rmt.g0", 3'b011, 3'b001, 3'd0, 1'b0);
    cycle("rmt.gap", 3'b010, 3'b000, 3'd0, 1'b0);
    cycle("rmt.g1c", 3'b010, 3'b010, 3'd1, 1'b0);
    cycle("rmt.end", 3'b000, 3'b000, 3'd1, 1'b0);

    @(negedge clk);
    #1;
    check("sb.drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
